// File: rtl/bank_linefill_buffer.sv
// Linefill buffer: assembles two BIU beats per MSHR id into a 256-bit line and announces completion to the IQ.
// Optional LFB_BYPASS_EN: completion pulse and line data are forwarded combinationally in the final-beat cycle.
module bank_linefill_buffer #(
  parameter int ID_WIDTH   = 6,
  parameter int BEAT_WIDTH = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    biu_lfb_rvalid_i,
  output logic                    biu_lfb_rready_o,
  input  logic [ID_WIDTH-1:0]     biu_lfb_rid_i,
  input  logic                    biu_lfb_rlast_i,
  input  logic [BEAT_WIDTH-1:0]   biu_lfb_rdata_i,
  output logic                    biu_isu_rvalid_o,
  output logic [ID_WIDTH-1:0]     biu_isu_rid_o,
  input  logic [ID_WIDTH-1:0]     iq_linefill_buffer_raddr_i,
  output logic [2*BEAT_WIDTH-1:0] linefill_buffer_data_o,
  input  logic                    sc_lfb_release_valid_i,
  input  logic [ID_WIDTH-1:0]     sc_lfb_release_id_i,
  output logic [ID_WIDTH:0]       lfb_entry_cnt_o,
  output logic                    lfb_proto_err_o
);

  localparam int NUM_ENTRY = 1 << ID_WIDTH;
  localparam int LINE_W    = 2 * BEAT_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } lfb_st_e;

  lfb_st_e             st_p0  [NUM_ENTRY];
  lfb_st_e             st_nxt [NUM_ENTRY];
  logic [LINE_W-1:0]   data_p0 [NUM_ENTRY];
  logic [ID_WIDTH:0]   cnt_p0, cnt_nxt;
  logic                err_p0, err_nxt;

  lfb_st_e beat_st;
  lfb_st_e rel_st;
  logic    beat_acc;
  logic    rel_ok;
  logic    line_done;
  logic    cnt_inc;

  assign beat_st   = st_p0[biu_lfb_rid_i];
  assign rel_st    = st_p0[sc_lfb_release_id_i];
  assign biu_lfb_rready_o = (beat_st != FULL);
  assign beat_acc  = biu_lfb_rvalid_i && (beat_st != FULL);
  // A FULL entry never accepts a beat, so release and accept always target different ids.
  assign rel_ok    = sc_lfb_release_valid_i && (rel_st == FULL);
  assign line_done = beat_acc && (beat_st == HALF);
  assign cnt_inc   = beat_acc && (beat_st == EMPTY);

  always_comb begin
    st_nxt  = st_p0;
    cnt_nxt = cnt_p0;
    err_nxt = err_p0;
    if (rel_ok) st_nxt[sc_lfb_release_id_i] = EMPTY;
    if (beat_acc) begin
      st_nxt[biu_lfb_rid_i] = (beat_st == EMPTY) ? HALF : FULL;
      if ((beat_st == EMPTY && biu_lfb_rlast_i) || (beat_st == HALF && !biu_lfb_rlast_i))
        err_nxt = 1'b1;
    end
    case ({cnt_inc, rel_ok})
      2'b10:   cnt_nxt = cnt_p0 + (ID_WIDTH+1)'(1);
      2'b01:   cnt_nxt = cnt_p0 - (ID_WIDTH+1)'(1);
      default: cnt_nxt = cnt_p0;
    endcase
  end

  // ---- stage p0: entry state, count, sticky error ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRY; i++) st_p0[i] <= EMPTY;
      cnt_p0 <= '0;
      err_p0 <= 1'b0;
    end else begin
      st_p0  <= st_nxt;
      cnt_p0 <= cnt_nxt;
      err_p0 <= err_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat_acc) begin
      if (beat_st == EMPTY) data_p0[biu_lfb_rid_i][BEAT_WIDTH-1:0]      <= biu_lfb_rdata_i;
      else                  data_p0[biu_lfb_rid_i][LINE_W-1:BEAT_WIDTH] <= biu_lfb_rdata_i;
    end
  end

  assign lfb_entry_cnt_o = cnt_p0;
  assign lfb_proto_err_o = err_p0;

`ifdef LFB_BYPASS_EN
  assign biu_isu_rvalid_o = line_done;
  assign biu_isu_rid_o    = line_done ? biu_lfb_rid_i : '0;

  always_comb begin
    linefill_buffer_data_o = data_p0[iq_linefill_buffer_raddr_i];
    if (line_done && (iq_linefill_buffer_raddr_i == biu_lfb_rid_i))
      linefill_buffer_data_o = {biu_lfb_rdata_i, data_p0[biu_lfb_rid_i][BEAT_WIDTH-1:0]};
  end
`else
  logic                cmpl_vld_p1;
  logic [ID_WIDTH-1:0] cmpl_rid_p1;

  // ---- stage p1: registered line-complete pulse; rid holds between pulses ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmpl_vld_p1 <= 1'b0;
      cmpl_rid_p1 <= '0;
    end else begin
      cmpl_vld_p1 <= line_done;
      if (line_done) cmpl_rid_p1 <= biu_lfb_rid_i;
    end
  end

  assign biu_isu_rvalid_o       = cmpl_vld_p1;
  assign biu_isu_rid_o          = cmpl_rid_p1;
  assign linefill_buffer_data_o = data_p0[iq_linefill_buffer_raddr_i];
`endif

endmodule

// File: tb/tb_bank_linefill_buffer.sv
// Randomized self-checking bench for bank_linefill_buffer against a per-entry beat-count model.
module tb_bank_linefill_buffer;
  localparam int IDW = 6;
  localparam int BW  = 128;
  localparam int N   = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            biu_lfb_rvalid_i;
  logic            biu_lfb_rready_o;
  logic [IDW-1:0]  biu_lfb_rid_i;
  logic            biu_lfb_rlast_i;
  logic [BW-1:0]   biu_lfb_rdata_i;
  logic            biu_isu_rvalid_o;
  logic [IDW-1:0]  biu_isu_rid_o;
  logic [IDW-1:0]  iq_linefill_buffer_raddr_i;
  logic [2*BW-1:0] linefill_buffer_data_o;
  logic            sc_lfb_release_valid_i;
  logic [IDW-1:0]  sc_lfb_release_id_i;
  logic [IDW:0]    lfb_entry_cnt_o;
  logic            lfb_proto_err_o;

  bank_linefill_buffer #(.ID_WIDTH(IDW), .BEAT_WIDTH(BW)) dut (
    .clk_i                      (clk_i),
    .rst_ni                     (rst_ni),
    .biu_lfb_rvalid_i           (biu_lfb_rvalid_i),
    .biu_lfb_rready_o           (biu_lfb_rready_o),
    .biu_lfb_rid_i              (biu_lfb_rid_i),
    .biu_lfb_rlast_i            (biu_lfb_rlast_i),
    .biu_lfb_rdata_i            (biu_lfb_rdata_i),
    .biu_isu_rvalid_o           (biu_isu_rvalid_o),
    .biu_isu_rid_o              (biu_isu_rid_o),
    .iq_linefill_buffer_raddr_i (iq_linefill_buffer_raddr_i),
    .linefill_buffer_data_o     (linefill_buffer_data_o),
    .sc_lfb_release_valid_i     (sc_lfb_release_valid_i),
    .sc_lfb_release_id_i        (sc_lfb_release_id_i),
    .lfb_entry_cnt_o            (lfb_entry_cnt_o),
    .lfb_proto_err_o            (lfb_proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: beats received per entry (0 empty, 1 half, 2 full), known line contents.
  int            m_beats [N];
  logic [2*BW-1:0] m_data [N];
  bit            m_w0 [N];
  bit            m_w1 [N];
  int            m_cnt;
  bit            m_err;
  logic [IDW-1:0] m_rid_hold;

  task automatic chk(input string tag, input logic [2*BW-1:0] obs, input logic [2*BW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_beats[i] = 0;
    m_cnt = 0;
    m_err = 1'b0;
    m_rid_hold = '0;
  endtask

  task automatic idle_inputs();
    biu_lfb_rvalid_i = 1'b0;
    biu_lfb_rid_i = '0;
    biu_lfb_rlast_i = 1'b0;
    biu_lfb_rdata_i = '0;
    sc_lfb_release_valid_i = 1'b0;
    sc_lfb_release_id_i = '0;
    iq_linefill_buffer_raddr_i = '0;
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cyc(input bit rv, input int rid, input bit rl, input logic [BW-1:0] rd,
                     input bit relv, input int relid, input int raddr);
    bit acc, relok, done;
    bit data_known;
    logic [2*BW-1:0] exp_d;
    biu_lfb_rvalid_i = rv;
    biu_lfb_rid_i = IDW'(rid);
    biu_lfb_rlast_i = rl;
    biu_lfb_rdata_i = rd;
    sc_lfb_release_valid_i = relv;
    sc_lfb_release_id_i = IDW'(relid);
    iq_linefill_buffer_raddr_i = IDW'(raddr);
    #1;
    acc   = rv && (m_beats[rid] < 2);
    done  = acc && (m_beats[rid] == 1);
    relok = relv && (m_beats[relid] == 2);
    chk("rready", biu_lfb_rready_o, m_beats[rid] < 2);
    exp_d = m_data[raddr];
    data_known = m_w0[raddr] && m_w1[raddr];
`ifdef LFB_BYPASS_EN
    if (done && raddr == rid) begin
      exp_d = {rd, m_data[rid][BW-1:0]};
      data_known = m_w0[rid];
    end
    chk("pulse_vld", biu_isu_rvalid_o, done);
    if (done) chk("pulse_rid", biu_isu_rid_o, IDW'(rid));
`endif
    if (data_known) chk("line_data", linefill_buffer_data_o, exp_d);
    if (acc) begin
      if (m_beats[rid] == 0) begin
        m_data[rid][BW-1:0] = rd;
        m_w0[rid] = 1'b1;
        if (rl) m_err = 1'b1;
        m_cnt++;
      end else begin
        m_data[rid][2*BW-1:BW] = rd;
        m_w1[rid] = 1'b1;
        if (!rl) m_err = 1'b1;
      end
      m_beats[rid]++;
    end
    if (relok) begin
      m_beats[relid] = 0;
      m_cnt--;
    end
    @(posedge clk_i);
    #1;
    chk("entry_cnt", lfb_entry_cnt_o, m_cnt);
    chk("proto_err", lfb_proto_err_o, m_err);
`ifndef LFB_BYPASS_EN
    if (done) m_rid_hold = IDW'(rid);
    chk("pulse_vld", biu_isu_rvalid_o, done);
    chk("pulse_rid", biu_isu_rid_o, m_rid_hold);
`endif
  endtask

  task automatic idle(input int raddr);
    cyc(1'b0, 0, 1'b0, '0, 1'b0, 0, raddr);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    chk("rst_vld", biu_isu_rvalid_o, 1'b0);
    chk("rst_rid", biu_isu_rid_o, '0);
    chk("rst_cnt", lfb_entry_cnt_o, '0);
    chk("rst_err", lfb_proto_err_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [BW-1:0] pat_a, pat_b;
    for (int i = 0; i < N; i++) begin
      m_w0[i] = 1'b0;
      m_w1[i] = 1'b0;
      m_data[i] = '0;
    end
    pat_a = {32{4'hA}};
    pat_b = {32{4'hB}};
    do_reset();

    // Scenario 1: simple refill of rid 5.
    cyc(1, 5, 0, pat_a, 0, 0, 5);
    cyc(1, 5, 1, pat_b, 0, 0, 5);
    idle(5);
    chk("s1_line", linefill_buffer_data_o, {pat_b, pat_a});
    chk("s1_cnt", lfb_entry_cnt_o, 1);

    // Scenario 2: interleaved rids 3 and 9.
    cyc(1, 3, 0, rnd128(), 0, 0, 3);
    cyc(1, 9, 0, rnd128(), 0, 0, 9);
    cyc(1, 9, 1, rnd128(), 0, 0, 9);
    cyc(1, 3, 1, rnd128(), 0, 0, 3);
    idle(3);
    idle(9);

    // Scenario 3: back-pressure on FULL rid 7 and same-cycle release+beat.
    cyc(1, 7, 0, rnd128(), 0, 0, 7);
    cyc(1, 7, 1, rnd128(), 0, 0, 7);
    cyc(1, 7, 0, rnd128(), 0, 0, 7);
    cyc(1, 7, 0, rnd128(), 1, 7, 7);
    cyc(1, 7, 0, rnd128(), 0, 0, 7);
    biu_lfb_rid_i = 7;
    #1;
    chk("s3_rready_half", biu_lfb_rready_o, 1'b1);

    // Scenario 5: wrong rlast on first beat, release of HALF entry ignored.
    chk("s5_err_pre", lfb_proto_err_o, 1'b0);
    cyc(1, 2, 1, rnd128(), 0, 0, 2);
    cyc(0, 2, 0, '0, 1, 2, 2);
    idle(2);
    chk("s5_err_hold", lfb_proto_err_o, 1'b1);
    cyc(1, 2, 1, rnd128(), 0, 0, 2);

    // Scenario 6: reset with rid 4 half-filled, then refill of rid 4.
    cyc(1, 4, 0, rnd128(), 0, 0, 4);
    do_reset();
    cyc(1, 4, 0, rnd128(), 0, 0, 4);
    cyc(1, 4, 1, rnd128(), 0, 0, 4);
    idle(4);

    // Scenario 4: every entry full, then release(0) with a beat on full rid 1.
    do_reset();
    for (int i = 0; i < N; i++) begin
      cyc(1, i, 0, rnd128(), 0, 0, i);
      cyc(1, i, 1, rnd128(), 0, 0, i);
    end
    chk("s4_cnt_max", lfb_entry_cnt_o, 64);
    cyc(1, 1, 0, rnd128(), 1, 0, 1);
    chk("s4_cnt_63", lfb_entry_cnt_o, 63);
    cyc(1, 0, 0, rnd128(), 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, '0, 1, i, i);

    // Randomized traffic on a small id set for dense interaction.
    for (int k = 0; k < 1500; k++) begin
      int rid;
      bit rl;
      rid = $urandom_range(0, 7);
      rl = (m_beats[rid] == 1);
      if ($urandom_range(0, 15) == 0) rl = !rl;
      cyc($urandom_range(0, 2) != 0, rid, rl, rnd128(),
          $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
